wide_add_seq: RTL and testbench

Multi-cycle sequencer that performs WORDS×16-bit add/subtract by time-multiplexing one 16-bit carry-select adder, one word per cycle, LSW first.
- Carry is registered between words.
- Valid/ready handshakes on the operand and result sides.
- Sits between the ALU issue logic and the writeback stage for wide (32/64-bit) arithmetic.

---
 rtl/wide_add_pkg.sv | 46 ++++
 rtl/csa_16_bit.sv | 40 ++++
 rtl/wide_add_seq.sv | 174 +++++++++++++++++
 tb/tb_wide_add_seq.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/wide_add_pkg.sv
// Purpose: shared types and constants for the wide multi-word add/subtract sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: FSM state type, per-word datapath width, and saturation constant
// generators sized for an N-bit result. Saturation values are built in a
// MAX_N-wide container; users slice the low N bits.
package wide_add_pkg;

    // Width of the single time-multiplexed adder slice.
    localparam int WORD_W = 16;

    // Upper bound on operand width supported by the saturation helpers.
    localparam int MAX_N = 1024;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Largest positive signed N-bit value: 0x7FF..F (low n-1 bits set).
    function automatic logic [MAX_N-1:0] sat_pos(input int n);
        logic [MAX_N-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_N; i++) begin
            if (i < n - 1) begin
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

    // Most negative signed N-bit value: 0x800..0 (only bit n-1 set).
    function automatic logic [MAX_N-1:0] sat_neg(input int n);
        logic [MAX_N-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_N; i++) begin
            if (i == n - 1) begin
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/csa_16_bit.sv
// Purpose: 16-bit carry-select adder; one word slice of the wide sequencer datapath.
// Latency: combinational, zero cycles.
// Backpressure: none (pure combinational logic).
//
// Ports:
//   a, b  - 16-bit addends
//   cin   - carry in
//   sum   - 16-bit sum
//   cout  - carry out of bit 15
//
// The low half ripples with the real carry in; the high half is computed for
// both possible carries and the low-half carry out selects between them.
module csa_16_bit
    import wide_add_pkg::*;
(
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    input  logic              cin,
    output logic [WORD_W-1:0] sum,
    output logic              cout
);

    localparam int HALF = WORD_W / 2;

    logic [HALF:0] lo_sum;
    logic [HALF:0] hi_sum0;
    logic [HALF:0] hi_sum1;
    logic [HALF:0] hi_sel;

    always_comb begin
        lo_sum  = {1'b0, a[HALF-1:0]} + {1'b0, b[HALF-1:0]} + {{HALF{1'b0}}, cin};
        hi_sum0 = {1'b0, a[WORD_W-1:HALF]} + {1'b0, b[WORD_W-1:HALF]};
        hi_sum1 = {1'b0, a[WORD_W-1:HALF]} + {1'b0, b[WORD_W-1:HALF]} + {{HALF{1'b0}}, 1'b1};
        // Late-arriving low-half carry only drives the final mux.
        hi_sel  = lo_sum[HALF] ? hi_sum1 : hi_sum0;
        sum     = {hi_sel[HALF-1:0], lo_sum[HALF-1:0]};
        cout    = hi_sel[HALF];
    end

endmodule

// File: rtl/wide_add_seq.sv
// Purpose: WORDS x 16-bit add/subtract, one word per cycle (LSW first) through one shared csa_16_bit.
// Latency: accept on edge k -> out_valid after edge k+WORDS; at most one op per WORDS+2 cycles.
// Backpressure: result held in DONE until out_ready; in_ready low from accept until retirement.
//
// Ports:
//   clk, reset            - rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready   - operand handshake (op_a, op_b, sub sampled only on accept)
//   op_a, op_b, sub       - N-bit operands; sub=1 computes A-B, else A+B
//   out_valid / out_ready - result handshake
//   result, cout, ovf     - N-bit wrapped (or saturated) result, final carry, signed overflow
//
// Build option: define WIDE_ADD_SAT_EN to saturate result on signed overflow
// (cout/ovf keep reporting the raw values). Latency is unchanged.
module wide_add_seq
    import wide_add_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [16*WORDS-1:0]   op_a,
    input  logic [16*WORDS-1:0]   op_b,
    input  logic                  sub,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [16*WORDS-1:0]   result,
    output logic                  cout,
    output logic                  ovf
);

    localparam int                N        = WORD_W * WORDS;
    localparam int                IDX_W    = $clog2(WORDS);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WORDS - 1);

`ifdef WIDE_ADD_SAT_EN
    localparam logic [MAX_N-1:0]  SAT_POS_FULL = sat_pos(N);
    localparam logic [MAX_N-1:0]  SAT_NEG_FULL = sat_neg(N);
    localparam logic [N-1:0]      SAT_POS      = SAT_POS_FULL[N-1:0];
    localparam logic [N-1:0]      SAT_NEG      = SAT_NEG_FULL[N-1:0];
`endif

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                          state;
    state_t                          state_nxt;

    // Operands are held word-addressable so the word index selects the
    // adder inputs directly. b_words holds B already inverted for subtract.
    logic [WORDS-1:0][WORD_W-1:0]    a_words;
    logic [WORDS-1:0][WORD_W-1:0]    b_words;
    logic [WORDS-1:0][WORD_W-1:0]    res_words;
    logic                            carry_q;
    logic [IDX_W-1:0]                idx;

    logic [WORD_W-1:0]               add_sum;
    logic                            add_cout;
    logic                            accept;
    logic                            last_word;
    logic                            a_msb;
    logic                            b_msb;
    logic                            ovf_nxt;

    // ------------------------------------------------------------------
    // Shared per-word adder
    // ------------------------------------------------------------------
    csa_16_bit u_csa (
        .a    (a_words[idx]),
        .b    (b_words[idx]),
        .cin  (carry_q),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (idx == LAST_IDX) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                // in_ready stays low here: a new op cannot be taken in the
                // same cycle the current result retires.
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath control terms
    // ------------------------------------------------------------------
    always_comb begin
        accept    = (state == IDLE) && in_valid;
        last_word = (state == RUN) && (idx == LAST_IDX);
        a_msb     = a_words[WORDS-1][WORD_W-1];
        b_msb     = b_words[WORDS-1][WORD_W-1];
        // Signed overflow of A + B' (B' = post-inversion operand): operands
        // agree in sign but the top sum bit disagrees.
        ovf_nxt   = (a_msb == b_msb) && (add_sum[WORD_W-1] != a_msb);
    end

    // ------------------------------------------------------------------
    // Operand, carry, index and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_words   <= '0;
            b_words   <= '0;
            res_words <= '0;
            carry_q   <= 1'b0;
            idx       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
        end else if (accept) begin
            a_words <= op_a;
            // Subtract as A + ~B + 1: the +1 enters as the first carry in.
            b_words <= sub ? ~op_b : op_b;
            carry_q <= sub;
            idx     <= '0;
        end else if (state == RUN) begin
            res_words[idx] <= add_sum;
            carry_q        <= add_cout;
            if (last_word) begin
                idx  <= '0;
                cout <= add_cout;
                ovf  <= ovf_nxt;
`ifdef WIDE_ADD_SAT_EN
                // Overrides the final-word write above; clamp toward the sign
                // of A (both operands share it whenever overflow occurs).
                if (ovf_nxt) begin
                    res_words <= a_msb ? SAT_NEG : SAT_POS;
                end
`endif
            end else begin
                idx <= idx + IDX_W'(1);
            end
        end
    end

    assign result = res_words;

endmodule

// File: tb/tb_wide_add_seq.sv
// Purpose: self-checking bench for wide_add_seq (WORDS=4, 64-bit operands).
// Latency: checks accept -> out_valid spacing of WORDS cycles.
// Backpressure: exercises held out_ready=0 in DONE and mid-operation async reset.
module tb_wide_add_seq;

    localparam int WORDS = 4;
    localparam int N     = 16 * WORDS;

    localparam logic signed [N+1:0] S_MAX = {3'b000, {(N-1){1'b1}}};
    localparam logic signed [N+1:0] S_MIN = {3'b111, {(N-1){1'b0}}};

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] op_a;
    logic [N-1:0] op_b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] result;
    logic         cout;
    logic         ovf;

    int n_checks = 0;
    int n_fails  = 0;

    wide_add_seq #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain N-bit modular arithmetic for result, unsigned compare
    // for the carry/borrow, exact signed arithmetic for overflow.
    task automatic model(input logic [N-1:0] a, input logic [N-1:0] b, input logic s,
                         output logic [N-1:0] r, output logic c, output logic o);
        logic [N:0]          u;
        logic signed [N+1:0] sa;
        logic signed [N+1:0] sb;
        logic signed [N+1:0] ex;
        sa = $signed({{2{a[N-1]}}, a});
        sb = $signed({{2{b[N-1]}}, b});
        if (s) begin
            u  = {1'b0, a} - {1'b0, b};
            c  = (a >= b);
            ex = sa - sb;
        end else begin
            u  = {1'b0, a} + {1'b0, b};
            c  = u[N];
            ex = sa + sb;
        end
        r = u[N-1:0];
        o = (ex > S_MAX) || (ex < S_MIN);
`ifdef WIDE_ADD_SAT_EN
        if (ex > S_MAX) r = {1'b0, {(N-1){1'b1}}};
        if (ex < S_MIN) r = {1'b1, {(N-1){1'b0}}};
`endif
    endtask

    function automatic logic [N-1:0] rand_opnd();
        logic [N-1:0] v;
        case ($urandom_range(0, 3))
            0:       v = {$urandom, $urandom};
            1:       v = {1'b0, {(N-1){1'b1}}} - N'($urandom_range(0, 3));
            2:       v = N'($urandom_range(0, 15));
            default: v = {1'b1, {(N-1){1'b0}}} + N'($urandom_range(0, 3));
        endcase
        return v;
    endfunction

    // Called at a negedge. Issues one op, checks latency and outputs, holds
    // the result for 'hold' cycles (optionally pushing in_valid against the
    // busy block), then retires it.
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic s,
                          input logic [N-1:0] er, input logic ec, input logic eo,
                          input int hold, input bit poke);
        int cyc;
        cyc = 0;
        while (!in_ready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("ready_before_issue", in_ready, 1);
        in_valid = 1'b1;
        op_a     = a;
        op_b     = b;
        sub      = s;
        @(negedge clk);
        // Scramble operands: the block must ignore them from here on.
        in_valid = 1'b0;
        op_a     = {$urandom, $urandom};
        op_b     = {$urandom, $urandom};
        sub      = 1'($urandom_range(0, 1));
        check("busy_after_accept", in_ready, 0);
        cyc = 0;
        while (!out_valid && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("latency", N'(cyc), N'(WORDS));
        check("result", result, er);
        check("cout", cout, ec);
        check("ovf", ovf, eo);
        for (int i = 0; i < hold; i++) begin
            if (poke) in_valid = 1'b1;
            @(negedge clk);
            check("hold_valid", out_valid, 1);
            check("hold_in_ready", in_ready, 0);
            check("hold_result", result, er);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("retired_valid", out_valid, 0);
        check("idle_ready", in_ready, 1);
    endtask

    task automatic run_rand(input logic [N-1:0] a, input logic [N-1:0] b, input logic s,
                            input int hold);
        logic [N-1:0] er;
        logic         ec;
        logic         eo;
        model(a, b, s, er, ec, eo);
        run_op(a, b, s, er, ec, eo, hold, 1'b0);
    endtask

    initial begin
        logic [N-1:0] sat_exp;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op_a      = '0;
        op_b      = '0;
        sub       = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_cout", cout, 0);
        check("rst_ovf", ovf, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Inter-word carry
        run_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0, 0, 1'b0);
        // Full ripple and wrap
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0, 1, 1'b0);
        // Positive signed overflow
`ifdef WIDE_ADD_SAT_EN
        sat_exp = 64'h7FFF_FFFF_FFFF_FFFF;
`else
        sat_exp = 64'h8000_0000_0000_0000;
`endif
        run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, sat_exp, 1'b0, 1'b1, 0, 1'b0);
        // Subtract with and without borrow
        run_op(64'h5, 64'h7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 0, 1'b0);
        run_op(64'h7, 64'h5, 1'b1, 64'h2, 1'b1, 1'b0, 0, 1'b0);
        // Back-pressure: 10 cycles held, in_valid pushed throughout
        run_op(64'h1111_2222_3333_4444, 64'h0101_0101_0101_0101, 1'b0,
               64'h1212_2323_3434_4545, 1'b0, 1'b0, 10, 1'b1);
        run_op(64'h10, 64'h20, 1'b0, 64'h30, 1'b0, 1'b0, 0, 1'b0);

        // Async reset in the middle of RUN (word index 2)
        in_valid = 1'b1;
        op_a     = 64'hFFFF_FFFF_FFFF_FFFF;
        op_b     = 64'hFFFF_FFFF_FFFF_FFFF;
        sub      = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrun_rst_out_valid", out_valid, 0);
        check("midrun_rst_result", result, 0);
        check("midrun_rst_in_ready", in_ready, 1);
        check("midrun_rst_cout", cout, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_op(64'h1234, 64'h1, 1'b0, 64'h1235, 1'b0, 1'b0, 0, 1'b0);

        // Randomized operations against the reference model
        for (int k = 0; k < 40; k++) begin
            run_rand(rand_opnd(), rand_opnd(), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
